// File: rtl/j1_io_pkg.sv
// Shared J1 I/O bus definitions: UART register addresses, STAT bit positions
// and the RX state type.
package j1_io_pkg;

  localparam logic [15:0] IO_UART_DATA = 16'h4030;
  localparam logic [15:0] IO_UART_STAT = 16'h4032;

  localparam int unsigned STAT_TX_BUSY    = 0;
  localparam int unsigned STAT_RX_VALID   = 1;
  localparam int unsigned STAT_RX_OVERRUN = 2;
  localparam int unsigned STAT_FRAME_ERR  = 3;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, start/data/stop FSM, framing check.
// Emits one-cycle rx_stb (good byte) or rx_ferr (bad stop bit).
module uart_rx
  import j1_io_pkg::*;
#(
  parameter int unsigned DIV = 208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_stb,
  output logic       rx_ferr
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    sh, sh_n;
  logic          sync1, sync2, prev;
  logic          fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      prev    <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
    end else begin
      sync1   <= rxd;
      sync2   <= sync1;
      prev    <= sync2;
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      sh      <= sh_n;
    end
  end

  assign fall = prev & ~sync2;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    sh_n      = sh;
    rx_stb    = 1'b0;
    rx_ferr   = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (fall) state_n = RX_START;
      end
      RX_START: begin
        // A line that is high again at mid-bit was a glitch, not a start bit.
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          sh_n  = {sync2, sh[7:1]};
          if (bit_idx == 3'd7) state_n = RX_STOP;
          else bit_idx_n = bit_idx + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          rx_stb  = sync2;
          rx_ferr = ~sync2;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign rx_data = sh;

endmodule

// File: rtl/uart_io.sv
// Memory-mapped UART on the J1 I/O bus: DATA/STAT registers, TX shifter, RX holding.
// Define UART_IO_RX_FIFO_EN for a 4-entry RX FIFO instead of a single holding register.
module uart_io
  import j1_io_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 24_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned DIV      = CLK_FREQ / BAUD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);

  logic data_sel, stat_sel, rd_data, rd_stat;
  logic unused_hi;

  assign data_sel  = (io_addr == IO_UART_DATA);
  assign stat_sel  = (io_addr == IO_UART_STAT);
  assign rd_data   = io_rd & data_sel;
  assign rd_stat   = io_rd & stat_sel;
  assign unused_hi = ^io_dout[15:8];

  // TX: frame is {stop, data, start}, shifted out LSB first.
  logic [9:0]    tx_sh;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic          tx_busy, tx_last, tx_load;

  // Accepting on the final stop-bit cycle gives gapless back-to-back frames.
  assign tx_last = tx_busy && (tx_cnt == BIT_LAST) && (tx_bit == 4'd9);
  assign tx_load = io_wr && data_sel && (!tx_busy || tx_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_busy <= 1'b0;
      tx_sh   <= '1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (tx_load) begin
      tx_busy <= 1'b1;
      tx_sh   <= {1'b1, io_dout[7:0], 1'b0};
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (tx_busy) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        tx_sh  <= {1'b1, tx_sh[9:1]};
        if (tx_bit == 4'd9) tx_busy <= 1'b0;
        else tx_bit <= tx_bit + 1'b1;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  assign uart_txd = tx_busy ? tx_sh[0] : 1'b1;

  logic [7:0] rx_byte;
  logic       rx_stb, rx_ferr;

  uart_rx #(.DIV(DIV)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .rxd     (uart_rxd),
    .rx_data (rx_byte),
    .rx_stb  (rx_stb),
    .rx_ferr (rx_ferr)
  );

  logic       rx_valid, pop, ovr_ev;
  logic [7:0] rx_head;

  assign pop = rd_data & rx_valid;

`ifdef UART_IO_RX_FIFO_EN
  logic [7:0] fifo [4];
  logic [1:0] wp, rp;
  logic [2:0] fcnt;
  logic       full, push_ok;

  assign full    = (fcnt == 3'd4);
  assign push_ok = rx_stb && (!full || pop);
  assign ovr_ev  = rx_stb && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      case ({push_ok, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo[wp] <= rx_byte;
  end

  assign rx_valid = (fcnt != 3'd0);
  assign rx_head  = fifo[rp];
`else
  logic [7:0] hold;
  logic       hold_v;

  assign ovr_ev = rx_stb && hold_v && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold   <= '0;
      hold_v <= 1'b0;
    end else if (rx_stb && (!hold_v || pop)) begin
      hold   <= rx_byte;
      hold_v <= 1'b1;
    end else if (pop) begin
      hold_v <= 1'b0;
    end
  end

  assign rx_valid = hold_v;
  assign rx_head  = hold;
`endif

  // A new event in the same cycle as a STAT read stays pending.
  logic rx_overrun, frame_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_overrun <= ovr_ev  | (rx_overrun & ~rd_stat);
      frame_err  <= rx_ferr | (frame_err  & ~rd_stat);
    end
  end

  always_comb begin
    io_din = '0;
    if (rd_data && rx_valid) begin
      io_din[7:0] = rx_head;
    end else if (rd_stat) begin
      io_din[STAT_TX_BUSY]    = tx_busy;
      io_din[STAT_RX_VALID]   = rx_valid;
      io_din[STAT_RX_OVERRUN] = rx_overrun;
      io_din[STAT_FRAME_ERR]  = frame_err;
    end
  end

endmodule

// File: tb/tb_uart_io.sv
// Scoreboard bench for uart_io at DIV=8: read and TX-line monitors pop expected values.
module tb_uart_io;

  localparam int DIV = 8;
  localparam logic [15:0] A_DATA = 16'h4030;
  localparam logic [15:0] A_STAT = 16'h4032;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [15:0] io_addr = '0;
  logic [15:0] io_dout = '0;
  logic [15:0] io_din;
  logic        uart_txd;
  logic        uart_rxd = 1'b1;

  int total = 0;
  int bad = 0;

  logic [15:0] exp_q[$];
  string       name_q[$];
  logic [7:0]  tx_q[$];

  uart_io #(.CLK_FREQ(8_000_000), .BAUD(1_000_000), .DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .io_addr  (io_addr),
    .io_dout  (io_dout),
    .io_din   (io_din),
    .uart_txd (uart_txd),
    .uart_rxd (uart_rxd)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h t=%0t", n, act, req, $time);
    end
  endtask

  // Read monitor
  logic [15:0] mon_e;
  string       mon_n;
  always @(negedge clk) begin
    if (io_rd) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read act=%h req=none", io_din);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        check(mon_n, io_din, mon_e);
      end
    end else begin
      check("idle_din", io_din, 16'h0000);
    end
  end

  // TX line monitor: checks every cycle of each frame against the queued byte
  int         tx_pos = -1;
  logic       tx_skip = 1'b0;
  logic [9:0] tx_exp;
  always @(negedge clk) begin
    if (reset) begin
      tx_pos = -1;
      tx_skip = 1'b0;
      tx_q.delete();
    end else if (tx_pos < 0) begin
      if (uart_txd == 1'b0) begin
        tx_pos = 1;
        if (tx_q.size() == 0) begin
          total++;
          bad++;
          tx_skip = 1'b1;
          $display("FAIL tx_unexpected_frame act=start req=idle t=%0t", $time);
        end else begin
          tx_exp = {1'b1, tx_q.pop_front(), 1'b0};
        end
      end
    end else begin
      if (!tx_skip) check("tx_bit", {15'b0, uart_txd}, {15'b0, tx_exp[tx_pos / DIV]});
      tx_pos++;
      if (tx_pos == 10 * DIV) begin
        tx_pos = -1;
        tx_skip = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] e, input string n);
    io_rd = 1'b1;
    io_addr = a;
    exp_q.push_back(e);
    name_q.push_back(n);
    step();
    io_rd = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    io_wr = 1'b1;
    io_addr = a;
    io_dout = d;
    step();
    io_wr = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (DIV) step();
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (DIV) step();
    end
    uart_rxd = stop;
    repeat (DIV) step();
    uart_rxd = 1'b1;
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    reset = 1'b0;
    step();

    check("txd_reset", {15'b0, uart_txd}, 16'h0001);
    rd(A_STAT, 16'h0000, "stat_reset");
    rd(A_DATA, 16'h0000, "data_empty");
    rd(16'h4034, 16'h0000, "unmapped");
    wr(A_STAT, 16'h00FF);
    rd(A_STAT, 16'h0000, "stat_after_wr");

    // TX A5; busy for 80 cycles, write mid-frame discarded
    tx_q.push_back(8'hA5);
    wr(A_DATA, 16'h00A5);
    for (int i = 0; i <= 80; i++) begin
      if (i == 40) wr(A_DATA, 16'h005A);
      else rd(A_STAT, (i < 80) ? 16'h0001 : 16'h0000, "tx_busy");
    end

    // Back-to-back: second write lands on the final stop-bit cycle
    tx_q.push_back(8'hC3);
    wr(A_DATA, 16'h00C3);
    repeat (79) step();
    tx_q.push_back(8'h81);
    wr(A_DATA, 16'h0081);
    check("b2b_start", {15'b0, uart_txd}, 16'h0000);
    repeat (85) step();

    // RX good byte
    send_byte(8'h3C, 1'b1);
    rd(A_STAT, 16'h0002, "rx_stat_valid");
    rd(A_DATA, 16'h003C, "rx_data");
    rd(A_STAT, 16'h0000, "rx_stat_clear");

    // Framing error
    send_byte(8'h55, 1'b0);
    rd(A_STAT, 16'h0008, "ferr_stat");
    rd(A_STAT, 16'h0000, "ferr_cleared");

    // False start glitch
    uart_rxd = 1'b0;
    repeat (2) step();
    uart_rxd = 1'b1;
    repeat (20) step();
    rd(A_STAT, 16'h0000, "glitch_stat");
    send_byte(8'h96, 1'b1);
    rd(A_STAT, 16'h0002, "after_glitch_stat");
    rd(A_DATA, 16'h0096, "after_glitch_data");

    // Overrun
`ifdef UART_IO_RX_FIFO_EN
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    rd(A_STAT, 16'h0006, "ovr_stat");
    rd(A_DATA, 16'h0011, "ovr_data0");
    rd(A_DATA, 16'h0022, "ovr_data1");
    rd(A_DATA, 16'h0033, "ovr_data2");
    rd(A_DATA, 16'h0044, "ovr_data3");
`else
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rd(A_STAT, 16'h0006, "ovr_stat");
    rd(A_DATA, 16'h0011, "ovr_data0");
`endif
    rd(A_STAT, 16'h0000, "ovr_cleared");
    rd(A_DATA, 16'h0000, "ovr_empty");

    // Push and pop on the same edge
    send_byte(8'h66, 1'b1);
    fork
      send_byte(8'h77, 1'b1);
      begin
        repeat (78) step();
        rd(A_DATA, 16'h0066, "pp_pop_old");
      end
    join
    rd(A_STAT, 16'h0002, "pp_stat");
    rd(A_DATA, 16'h0077, "pp_new");

    // Reset mid-frame
    tx_q.push_back(8'hF0);
    wr(A_DATA, 16'h00F0);
    repeat (30) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("txd_after_reset", {15'b0, uart_txd}, 16'h0001);
    rd(A_STAT, 16'h0000, "stat_after_reset");
    repeat (5) step();

    check("read_queue_drained", 16'(exp_q.size()), 16'h0000);
    check("tx_queue_drained", 16'(tx_q.size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
